// File: rtl/load_use_hazard_unit_pkg.sv
// Shared pipeline definitions for the load-use hazard logic.
package load_use_hazard_unit_pkg;

    // Default register-index width of the pipeline.
    localparam int REG_ADDR_W = 5;

    // Hard-wired zero register; writes to it never create a dependency.
    localparam int X0 = 0;

    // Two-state stall sequencer.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/load_use_hazard_unit_src_match.sv
// Per-source comparator: flags an ID source that depends on a load in EX.
module load_use_hazard_unit_src_match #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic              rs_used,
    input  logic              valid_id,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic              memread_ex,
    input  logic              valid_ex,
    output logic              match
);
    import load_use_hazard_unit_pkg::*;

    // A load into x0 never produces data, so it cannot cause a hazard.
    always_comb begin
        match = valid_id & rs_used & valid_ex & memread_ex
              & (rd_ex != ADDR_W'(X0)) & (rs == rd_ex);
    end

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard unit: one-cycle front-end stall plus a bubble into ID/EX,
// then registered per-operand select flags for the EX forwarding muxes.
module load_use_hazard_unit #(
    parameter int REG_ADDR_W = load_use_hazard_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  rs1_used_ID,
    input  logic                  rs2_used_ID,
    input  logic                  valid_ID,
    input  logic [REG_ADDR_W-1:0] rd_EX,
    input  logic                  memread_EX,
    input  logic                  valid_EX,
    input  logic                  flush_ID,
    input  logic                  hold_ext,
    output logic                  stall_IF,
    output logic                  stall_ID,
    output logic                  bubble_EX,
    output logic                  stall_EN1_EX,
    output logic                  stall_EN2_EX,
    output logic [CNT_W-1:0]      stall_cnt
);
    import load_use_hazard_unit_pkg::*;

    logic      m1;
    logic      m2;
    logic      hz;
    hz_state_t state_q;
    hz_state_t state_d;
    logic      pend1_q;
    logic      pend2_q;
    logic      pend1_d;
    logic      pend2_d;
    logic      en1_d;
    logic      en2_d;

    load_use_hazard_unit_src_match #(.ADDR_W(REG_ADDR_W)) u_match1 (
        .rs         (rs1_ID),
        .rs_used    (rs1_used_ID),
        .valid_id   (valid_ID),
        .rd_ex      (rd_EX),
        .memread_ex (memread_EX),
        .valid_ex   (valid_EX),
        .match      (m1)
    );

    load_use_hazard_unit_src_match #(.ADDR_W(REG_ADDR_W)) u_match2 (
        .rs         (rs2_ID),
        .rs_used    (rs2_used_ID),
        .valid_id   (valid_ID),
        .rd_ex      (rd_EX),
        .memread_ex (memread_EX),
        .valid_ex   (valid_EX),
        .match      (m2)
    );

    // A flushed ID instruction is dead, so it cannot stall the pipe.
    always_comb begin
        hz = (m1 | m2) & ~flush_ID;
    end

    // Next-state, pending operands, next flags and combinational stall outputs.
    always_comb begin
        state_d   = state_q;
        pend1_d   = pend1_q;
        pend2_d   = pend2_q;
        en1_d     = 1'b0;
        en2_d     = 1'b0;
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        bubble_EX = 1'b0;
        if (!rst_n) begin
            // Outputs stay quiet while reset is held.
            state_d = RUN;
        end else if (hold_ext) begin
            // External freeze owns the pipeline; everything here holds.
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            en1_d    = stall_EN1_EX;
            en2_d    = stall_EN2_EX;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        stall_IF  = 1'b1;
                        stall_ID  = 1'b1;
                        bubble_EX = 1'b1;
                        pend1_d   = m1;
                        pend2_d   = m2;
                        state_d   = STALL;
                    end else begin
                        pend1_d = 1'b0;
                        pend2_d = 1'b0;
                    end
                end
                STALL: begin
                    // EX holds the bubble, so no new hazard is looked for here.
                    pend1_d = 1'b0;
                    pend2_d = 1'b0;
                    state_d = RUN;
                    if (!flush_ID) begin
                        en1_d = pend1_q;
                        en2_d = pend2_q;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, pending operand bits and select flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pend1_q      <= 1'b0;
            pend2_q      <= 1'b0;
            stall_EN1_EX <= 1'b0;
            stall_EN2_EX <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            stall_EN1_EX <= en1_d;
            stall_EN2_EX <= en2_d;
        end
    end

    // Saturating count of bubble cycles; hold_ext suppresses the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bubble_EX && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

Detects load-use hazards between the instruction in ID and a load in EX. It stalls the front end for exactly one cycle, injects a bubble into ID/EX, and then drives the per-operand select flags `stall_EN1_EX` and `stall_EN2_EX`. These flags are registered and valid in the cycle the dependent instruction occupies EX, where they steer the EX operand muxes to the loaded data (`dataout_MEM`). The unit sits beside the ID/EX pipeline register and is the producer of those select flags.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register-index width.
- `CNT_W`, default 32: width of the stall-cycle statistics counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_ID`  in  REG_ADDR_W  source register 1 of the ID instruction.
- `rs2_ID`  in  REG_ADDR_W  source register 2 of the ID instruction.
- `rs1_used_ID`  in  1  ID instruction reads rs1.
- `rs2_used_ID`  in  1  ID instruction reads rs2.
- `valid_ID`  in  1  ID holds a real instruction.
- `rd_EX`  in  REG_ADDR_W  destination register of the EX instruction.
- `memread_EX`  in  1  EX instruction is a load.
- `valid_EX`  in  1  EX holds a real instruction.
- `flush_ID`  in  1  taken branch/jump; kills the ID instruction.
- `hold_ext`  in  1  external pipeline freeze (data-memory wait); the unit holds all state.
- `stall_IF`  out  1  hold the PC.
- `stall_ID`  out  1  hold the IF/ID register.
- `bubble_EX`  out  1  load a NOP into ID/EX.
- `stall_EN1_EX`  out  1  EX operand 1 takes the loaded data.
- `stall_EN2_EX`  out  1  EX operand 2 takes the loaded data.
- `stall_cnt`  out  CNT_W  saturating count of load-use stall cycles.

## Operation
Hazard terms (combinational):
- `m1` = `valid_ID` & `rs1_used_ID` & `valid_EX` & `memread_EX` & (`rd_EX`≠0) & (`rs1_ID`==`rd_EX`).
- `m2` is the same expression using rs2.
- `hz` = (`m1`|`m2`) & ~`flush_ID`.

FSM states are RUN and STALL.
- **RUN, `hz`=1:**
  - Assert `stall_IF`, `stall_ID`, `bubble_EX` combinationally.
  - Latch `m1`/`m2` into `pend1`/`pend2`.
  - Go to STALL.
- **RUN, `hz`=0:** no stall outputs; `pend` stays 0.
- **STALL, every case:**
  - Stall outputs are low; the dependent instruction advances into EX.
  - On that edge `stall_EN1_EX`←`pend1` and `stall_EN2_EX`←`pend2`; clear `pend`; go to RUN.
  - `hz` is not evaluated in STALL: the EX stage holds the bubble, so no new hazard is possible.
- **`stall_EN*_EX` in every other cycle:** registered 0, so each flag is high for exactly one cycle.
- **`flush_ID` in STALL (defensive):** clear `pend` and the flags; go to RUN.
- **`hold_ext`=1:**
  - Freeze the FSM, `pend`, flags and counter.
  - `stall_IF`, `stall_ID` are forced 1 and `bubble_EX` is forced 0; the external freeze owns the pipeline.
- **Counter:** `stall_cnt` +1 per cycle in which `bubble_EX` is asserted; it saturates at all-ones.
- **x0:** a load to x0 never raises a hazard.
- **Both sources match:** both flags are set.

## Timing
- Reset values: all outputs 0, FSM=RUN, `pend`=0, `stall_cnt`=0. Reset is asynchronous, and an assertion mid-STALL returns to RUN immediately.
- Detect-to-stall latency is 0 cycles (combinational in cycle N).
- Flag latency: flags are high in cycle N+2, the cycle the dependent instruction is in EX. In that cycle the load is in MEM/WB and `dataout_MEM` is valid.
- Stall length is exactly one cycle per load-use hazard.
- Back-to-back dependent loads (e.g. `lw x1`; `lw x2,0(x1)`; `add x3,x2`) produce two independent one-cycle stalls.
- With `hold_ext`, flags and `pend` are held across the freeze and asserted in the first unfrozen EX cycle.

## Structure
- Shared pipeline package holds:
  - the FSM state enum (RUN, STALL);
  - `REG_ADDR_W`;
  - the constant `X0 = 0`.
- Sub-module `src_match`: one per source; parameterised comparator producing `m1`/`m2`, instantiated twice.
- Counter inline.

## Test plan
- **rs1 load-use:** `lw x5` in EX, ID reads `rs1`=x5 → stall_IF/ID/bubble=1 for 1 cycle; stall_EN1_EX=1, EN2=0 two cycles later; stall_cnt=1.
- **Double match:** `rs1`=`rs2`=x7, load to x7 → one stall; both flags=1 for one cycle.
- **x0 and non-load:** load to x0 with `rs1`=0, and an `add` writing x5 with `rs1`=x5 → no stall, flags 0, stall_cnt unchanged.
- **Flush priority:** hazard condition with `flush_ID`=1 → no stall, no flags.
- **Freeze:** `hold_ext`=1 for 3 cycles while in STALL → state held; after release, flags assert once.
- **Reset and saturation:** `rst_n` low mid-STALL → all outputs 0 asynchronously. Separately, with CNT_W=2, five stalls → stall_cnt=3.
